// File: rtl/reg_dump_tx.sv
// reg_dump_tx
//   Snapshots a register set on request and streams it out one byte at a
//   time through a UART-style start/done handshake. Registers go out in
//   order reg0..reg(num_regs-1), each most-significant byte first.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   dump_start  one-cycle request; accepted only while idle
//   in_reg0..7  live register values (len_data bits each)
//   tx_done     one-cycle pulse from the transmitter: current byte sent
//   tx_start    one-cycle pulse: transmitter should send tx_data
//   tx_data     registered byte to transmit, held until tx_done
//   busy        high while a dump is in progress (SEND/WAIT/DONE)
//   dump_done   one-cycle pulse after the last byte is acknowledged
//
// The port list carries eight register inputs; num_regs selects how many
// of them (starting at in_reg0) form the dump, so num_regs must be <= 8.
module reg_dump_tx #(
   parameter int len_data = 32,
   parameter int num_regs = 8,
   parameter int len_byte = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                dump_start,
   input  logic [len_data-1:0] in_reg0,
   input  logic [len_data-1:0] in_reg1,
   input  logic [len_data-1:0] in_reg2,
   input  logic [len_data-1:0] in_reg3,
   input  logic [len_data-1:0] in_reg4,
   input  logic [len_data-1:0] in_reg5,
   input  logic [len_data-1:0] in_reg6,
   input  logic [len_data-1:0] in_reg7,
   input  logic                tx_done,
   output logic                tx_start,
   output logic [len_byte-1:0] tx_data,
   output logic                busy,
   output logic                dump_done
);

   localparam int TOTAL     = num_regs * len_data;
   localparam int NUM_BYTES = TOTAL / len_byte;
   localparam int CNT_W     = $clog2(NUM_BYTES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT,
      DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   byte_cnt;
   logic [TOTAL-1:0]   snapshot;
   logic [8*len_data-1:0] all_in;
   logic [TOTAL-1:0]   flat_in;

   // reg0 sits in the most-significant position so that byte k of the
   // stream is simply the k-th byte counted from the top of the vector.
   assign all_in  = {in_reg0, in_reg1, in_reg2, in_reg3,
                     in_reg4, in_reg5, in_reg6, in_reg7};
   assign flat_in = all_in[8*len_data-1 -: TOTAL];

   function automatic logic [len_byte-1:0] pick_byte(
      input logic [TOTAL-1:0] flat,
      input logic [CNT_W-1:0] idx
   );
      logic [TOTAL-1:0] shifted;
      shifted = flat << (len_byte * int'(idx));
      return shifted[TOTAL-1 -: len_byte];
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      busy      = 1'b0;
      dump_done = 1'b0;
      case (state)
         IDLE: begin
            if (dump_start) state_nxt = SEND;
         end
         SEND: begin
            tx_start  = 1'b1;
            busy      = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (tx_done) state_nxt = (byte_cnt == LAST) ? DONE : SEND;
         end
         DONE: begin
            busy      = 1'b1;
            dump_done = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // tx_data is loaded on the edge that enters SEND, so it is already valid
   // while tx_start is high. Byte 0 comes straight from the inputs because
   // the snapshot is being written on that same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt <= '0;
         snapshot <= '0;
         tx_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dump_start) begin
                  snapshot <= flat_in;
                  byte_cnt <= '0;
                  tx_data  <= pick_byte(flat_in, '0);
               end
            end
            WAIT: begin
               if (tx_done && (byte_cnt != LAST)) begin
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  tx_data  <= pick_byte(snapshot, byte_cnt + CNT_W'(1));
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_tx.sv
module tb_reg_dump_tx;

   logic        clk;
   logic        reset;
   logic        dump_start;
   logic [31:0] in_reg [8];
   logic        tx_done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy;
   logic        dump_done;

   int tests;
   int fails;

   logic [7:0] got [64];
   int n_starts, n_dones, done_cycle, stab_err, early_err, busy_err;

   reg_dump_tx #(.len_data(32), .num_regs(8), .len_byte(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .dump_start(dump_start),
      .in_reg0   (in_reg[0]),
      .in_reg1   (in_reg[1]),
      .in_reg2   (in_reg[2]),
      .in_reg3   (in_reg[3]),
      .in_reg4   (in_reg[4]),
      .in_reg5   (in_reg[5]),
      .in_reg6   (in_reg[6]),
      .in_reg7   (in_reg[7]),
      .tx_done   (tx_done),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .busy      (busy),
      .dump_done (dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // Runs one dump, acting as the transmitter: tx_done is returned `delay`
   // cycles after each tx_start. Inputs are driven and outputs sampled on the
   // falling edge. hook 1: overwrite in_reg0 the cycle after acceptance;
   // hook 2: second dump_start in the first WAIT cycle of byte 5;
   // hook 3: assert reset in the first WAIT cycle of byte 10 and return.
   task automatic do_dump(input int delay, input int hook);
      int cnt, extra;
      bit waiting, stop, done_seen;
      logic [7:0] cur;
      n_starts = 0; n_dones = 0; done_cycle = -1;
      stab_err = 0; early_err = 0; busy_err = 0;
      cnt = 0; extra = 0; waiting = 0; stop = 0; done_seen = 0; cur = 8'h00;
      @(negedge clk);
      dump_start = 1'b1;
      for (int cyc = 1; cyc <= 32*(delay+1) + 20 && !stop; cyc++) begin
         @(negedge clk);
         dump_start = 1'b0;
         tx_done    = 1'b0;
         if (hook == 1 && cyc == 1) in_reg[0] = 32'hFFFF_FFFF;
         if (!done_seen && busy !== 1'b1) busy_err++;
         if (dump_done === 1'b1) begin
            n_dones++;
            if (!done_seen) done_cycle = cyc;
            done_seen = 1'b1;
         end
         if (tx_start === 1'b1) begin
            if (waiting) early_err++;
            if (n_starts < 64) got[n_starts] = tx_data;
            n_starts++;
            waiting = 1'b1;
            cnt = 0;
            cur = tx_data;
         end else if (waiting) begin
            cnt++;
            if (tx_data !== cur) stab_err++;
            if (hook == 2 && n_starts == 6 && cnt == 1) dump_start = 1'b1;
            if (hook == 3 && n_starts == 11 && cnt == 1) begin
               reset = 1'b1;
               stop  = 1'b1;
            end else if (cnt == delay) begin
               tx_done = 1'b1;
               waiting = 1'b0;
            end
         end
         if (done_seen) begin
            extra++;
            if (extra > 10) stop = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      int starts;
      reset = 1'b1; dump_start = 1'b0; tx_done = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
      tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
      tests++; if (dump_done !== 1'b0) begin fails++; $display("FAIL reset_dump_done: got %b, required 0", dump_done); end
      reset = 1'b0;
      starts = 0;
      for (int i = 0; i < 6; i++) begin
         tx_done = (i % 2 == 0);
         @(negedge clk);
         if (tx_start === 1'b1 || busy === 1'b1) starts++;
      end
      tx_done = 1'b0;
      tests++; if (starts != 0) begin fails++; $display("FAIL idle_tx_done: got %0d active cycles, required 0", starts); end
      // reset wins over a simultaneous dump_start
      reset = 1'b1; dump_start = 1'b1; tx_done = 1'b1;
      @(negedge clk);
      reset = 1'b0; dump_start = 1'b0; tx_done = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_priority_busy: got %b, required 0", busy); end
      @(negedge clk);
      tests++; if (tx_start !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_priority_start: got tx_start=%b busy=%b, required 0 0", tx_start, busy); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_regs [8];
      logic [31:0] w;
      logic [7:0]  e;
      exp_regs = '{32'h1122_3344, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
      for (int i = 0; i < 8; i++) in_reg[i] = exp_regs[i];
      do_dump(1, 0);
      tests++; if (n_starts != 32) begin fails++; $display("FAIL basic_count: got %0d tx_start, required 32", n_starts); end
      tests++; if (done_cycle != 65) begin fails++; $display("FAIL basic_done_cycle: got %0d, required 65", done_cycle); end
      tests++; if (n_dones != 1) begin fails++; $display("FAIL basic_dones: got %0d, required 1", n_dones); end
      tests++; if (busy_err != 0) begin fails++; $display("FAIL basic_busy: got %0d low cycles, required 0", busy_err); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b, required 0", busy); end
      for (int k = 0; k < 32; k++) begin
         w = exp_regs[k/4];
         w = w >> (24 - 8*(k%4));
         e = w[7:0];
         tests++; if (got[k] !== e) begin fails++; $display("FAIL basic_byte%0d: got %h, required %h", k, got[k], e); end
      end
   endtask

   task automatic test_isolation();
      in_reg[0] = 32'h1122_3344;
      do_dump(1, 1);
      tests++; if (got[0] !== 8'h11) begin fails++; $display("FAIL iso_byte0: got %h, required 11", got[0]); end
      tests++; if (got[1] !== 8'h22) begin fails++; $display("FAIL iso_byte1: got %h, required 22", got[1]); end
      tests++; if (got[2] !== 8'h33) begin fails++; $display("FAIL iso_byte2: got %h, required 33", got[2]); end
      tests++; if (got[3] !== 8'h44) begin fails++; $display("FAIL iso_byte3: got %h, required 44", got[3]); end
      tests++; if (n_starts != 32) begin fails++; $display("FAIL iso_count: got %0d, required 32", n_starts); end
      in_reg[0] = 32'h1122_3344;
   endtask

   task automatic test_busy_reject();
      do_dump(1, 2);
      tests++; if (n_starts != 32) begin fails++; $display("FAIL reject_count: got %0d tx_start, required 32", n_starts); end
      tests++; if (n_dones != 1) begin fails++; $display("FAIL reject_dones: got %0d, required 1", n_dones); end
      tests++; if (got[31] !== 8'hEF) begin fails++; $display("FAIL reject_last_byte: got %h, required ef", got[31]); end
   endtask

   task automatic test_slow();
      do_dump(100, 0);
      tests++; if (stab_err != 0) begin fails++; $display("FAIL slow_stable: got %0d changes, required 0", stab_err); end
      tests++; if (early_err != 0) begin fails++; $display("FAIL slow_early_start: got %0d, required 0", early_err); end
      tests++; if (n_starts != 32) begin fails++; $display("FAIL slow_count: got %0d, required 32", n_starts); end
      tests++; if (done_cycle != 3233) begin fails++; $display("FAIL slow_done_cycle: got %0d, required 3233", done_cycle); end
      tests++; if (got[28] !== 8'hDE) begin fails++; $display("FAIL slow_byte28: got %h, required de", got[28]); end
   endtask

   task automatic test_reset_mid();
      int starts;
      in_reg[0] = 32'hA1B2_C3D4;
      do_dump(1, 3);
      tests++; if (n_starts != 11) begin fails++; $display("FAIL mid_reached: got %0d bytes before reset, required 11", n_starts); end
      @(negedge clk);
      tests++; if (tx_start !== 1'b0 || busy !== 1'b0 || dump_done !== 1'b0) begin fails++; $display("FAIL mid_ctrl: got tx_start=%b busy=%b dump_done=%b, required 0 0 0", tx_start, busy, dump_done); end
      tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL mid_tx_data: got %h, required 00", tx_data); end
      reset = 1'b0;
      starts = 0;
      for (int i = 0; i < 4; i++) begin
         tx_done = (i == 1);
         @(negedge clk);
         if (tx_start === 1'b1) starts++;
      end
      tx_done = 1'b0;
      tests++; if (starts != 0) begin fails++; $display("FAIL mid_no_restart: got %0d tx_start, required 0", starts); end
      do_dump(1, 0);
      tests++; if (got[0] !== 8'hA1) begin fails++; $display("FAIL mid_restart_byte0: got %h, required a1", got[0]); end
      tests++; if (got[1] !== 8'hB2) begin fails++; $display("FAIL mid_restart_byte1: got %h, required b2", got[1]); end
      tests++; if (n_starts != 32) begin fails++; $display("FAIL mid_restart_count: got %0d, required 32", n_starts); end
      tests++; if (done_cycle != 65) begin fails++; $display("FAIL mid_restart_done: got %0d, required 65", done_cycle); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      dump_start = 1'b0;
      tx_done = 1'b0;
      for (int i = 0; i < 8; i++) in_reg[i] = 32'h0;
      test_reset();
      test_basic();
      test_isolation();
      test_busy_reject();
      test_slow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
